// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: operation encoding and arbiter FSM states.
package cache_arbiter_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  // Width of a saturating counter that must reach 'limit'; never narrower than 1 bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cache_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so last_grant+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module cache_rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   winner_o,
  output logic            any_o
);

  logic [NREQ-1:0] rot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic sel_bit;
    always_comb begin
      sel_bit = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if (j == ((int'(last_i) + 1 + gi) % NREQ)) begin
          sel_bit = req_i[j];
        end
      end
    end
    assign rot[gi] = sel_bit;
  end

  int unsigned offset;
  int unsigned win_full;

  always_comb begin
    offset = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = k;
      end
    end
    win_full = (int'(last_i) + 1 + offset) % NREQ;
  end

  assign any_o    = |rot;
  assign winner_o = win_full[IW-1:0];

endmodule

// File: rtl/cache_arbiter.sv
// Shares one next-level cache port among NREQ requesters with round-robin arbitration,
// evict broadcast and a watchdog that aborts transactions to a hung next level.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_request,
  input  logic [NREQ-1:0]          req_operation,
  input  logic [NREQ*ADDRBITS-1:0] req_addr,
  input  logic [NREQ*DATABITS-1:0] req_wdata,
  output logic [NREQ-1:0]          req_valid,
  output logic [DATABITS-1:0]      req_rdata,
  output logic [NREQ-1:0]          req_evict,
  output logic                     nl_request,
  output logic                     nl_operation,
  output logic [ADDRBITS-1:0]      nl_addr,
  output logic [DATABITS-1:0]      nl_wdata,
  input  logic [DATABITS-1:0]      nl_rdata,
  input  logic                     nl_valid,
  input  logic                     nl_evict,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_t            state_q;
  logic [NREQ-1:0]       req_valid_q;
  logic [DATABITS-1:0]   req_rdata_q;
  logic                  nl_request_q;
  op_t                   op_q;
  logic [ADDRBITS-1:0]   addr_q;
  logic [DATABITS-1:0]   wdata_q;
  logic [IW-1:0]         grant_id_q;
  logic [IW-1:0]         last_grant_q;
  logic                  timeout_err_q;
  logic [CW-1:0]         wdog_q;
  logic [CW-1:0]         wdog_d;

  logic [IW-1:0]         winner;
  logic                  any_req;

  logic [ADDRBITS-1:0]   addr_arr  [NREQ];
  logic [DATABITS-1:0]   wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDRBITS +: ADDRBITS];
    assign wdata_arr[gi] = req_wdata[gi*DATABITS +: DATABITS];
  end

  cache_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i    (req_request),
    .last_i   (last_grant_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // Saturating watchdog increment; only the ISSUE state consumes it.
  always_comb begin
    wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      req_valid_q   <= '0;
      req_rdata_q   <= '0;
      nl_request_q  <= 1'b0;
      op_q          <= OP_READ;
      addr_q        <= '0;
      wdata_q       <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= IW'(NREQ - 1);
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      req_valid_q <= '0;
      case (state_q)
        IDLE: begin
          // An evict from below holds off new grants until it drops.
          if (!nl_evict && any_req) begin
            op_q         <= op_t'(req_operation[winner]);
            addr_q       <= addr_arr[winner];
            wdata_q      <= wdata_arr[winner];
            grant_id_q   <= winner;
            wdog_q       <= '0;
            nl_request_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (nl_valid) begin
            req_rdata_q             <= nl_rdata;
            req_valid_q[grant_id_q] <= 1'b1;
            nl_request_q            <= 1'b0;
            state_q                 <= RESPOND;
          end else begin
            wdog_q <= wdog_d;
            if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
              timeout_err_q <= 1'b1;
              last_grant_q  <= grant_id_q;
              nl_request_q  <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end
        RESPOND: begin
          last_grant_q <= grant_id_q;
          state_q      <= IDLE;
        end
        default: begin
          nl_request_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_valid    = req_valid_q;
  assign req_rdata    = req_rdata_q;
  assign req_evict    = {NREQ{nl_evict}};
  assign nl_request   = nl_request_q;
  assign nl_operation = op_q;
  assign nl_addr      = addr_q;
  assign nl_wdata     = wdata_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: vector table of transactions plus hand-written
// evict, watchdog and reset sequences; completions are checked against a scoreboard queue.
module tb_cache_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_request;
  logic [1:0]  req_operation;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_valid;
  logic [31:0] req_rdata;
  logic [1:0]  req_evict;
  logic        nl_request;
  logic        nl_operation;
  logic [31:0] nl_addr;
  logic [31:0] nl_wdata;
  logic [31:0] nl_rdata;
  logic        nl_valid;
  logic        nl_evict;
  logic [0:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  cache_arbiter #(
    .NREQ     (2),
    .ADDRBITS (32),
    .DATABITS (32),
    .TIMEOUT  (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_request   (req_request),
    .req_operation (req_operation),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_valid     (req_valid),
    .req_rdata     (req_rdata),
    .req_evict     (req_evict),
    .nl_request    (nl_request),
    .nl_operation  (nl_operation),
    .nl_addr       (nl_addr),
    .nl_wdata      (nl_wdata),
    .nl_rdata      (nl_rdata),
    .nl_valid      (nl_valid),
    .nl_evict      (nl_evict),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  op;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
    int          waits;
    logic [31:0] rdata;
    int          g;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Completion monitor: every req_valid pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (req_valid != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_req_valid", 64'(req_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("req_valid", 64'(req_valid), 64'(e.valid));
        check("req_rdata", 64'(req_rdata), 64'(e.rdata));
        $display("[TB] completion valid=%b rdata=%h", req_valid, req_rdata);
      end
    end
  end

  task automatic finish_txn(input int g, input logic [31:0] rd);
    exp_t e;
    e.valid = 2'b01 << g;
    e.rdata = rd;
    sb.push_back(e);
    nl_valid = 1'b1;
    nl_rdata = rd;
    tick();
    check("busy_respond", 64'(busy), 64'd1);
    check("nl_request_respond", 64'(nl_request), 64'd0);
    nl_valid = 1'b0;
    nl_rdata = 32'h5A5A_5A5A;
    tick();
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic [31:0] ea;
    logic [31:0] ew;
    logic        eo;
    v  = vecs[idx];
    ea = (v.g == 1) ? v.a1 : v.a0;
    ew = (v.g == 1) ? v.w1 : v.w0;
    eo = v.op[v.g];
    req_request   = v.req;
    req_operation = v.op;
    req_addr      = {v.a1, v.a0};
    req_wdata     = {v.w1, v.w0};
    tick();
    check("grant_id", 64'(grant_id), 64'(v.g));
    check("nl_request", 64'(nl_request), 64'd1);
    check("nl_addr", 64'(nl_addr), 64'(ea));
    check("nl_operation", 64'(nl_operation), 64'(eo));
    check("nl_wdata", 64'(nl_wdata), 64'(ew));
    $display("[TB] vec %0d grant=%0d op=%0d addr=%h", idx, grant_id, nl_operation, nl_addr);
    // Scramble requester inputs mid-transaction; the latched values must not move.
    req_addr      = ~req_addr;
    req_wdata     = ~req_wdata;
    req_operation = ~req_operation;
    for (int w = 0; w < v.waits; w++) begin
      nl_rdata = $urandom;
      tick();
      check("nl_request_hold", 64'(nl_request), 64'd1);
      check("nl_addr_hold", 64'(nl_addr), 64'(ea));
      check("nl_op_hold", 64'(nl_operation), 64'(eo));
    end
    finish_txn(v.g, v.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vecs[0] = '{2'b01, 2'b00, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 3, 32'hDEAD_BEEF, 0};
    vecs[1] = '{2'b11, 2'b10, 32'h0000_2000, 32'h0000_3000, 32'h1111_1111, 32'h2222_2222, 0, 32'h0BAD_0001, 1};
    vecs[2] = '{2'b11, 2'b01, 32'h0000_4000, 32'h0000_5000, 32'h3333_3333, 32'h4444_4444, 0, 32'h0BAD_0002, 0};
    vecs[3] = '{2'b11, 2'b00, 32'h0000_6000, 32'h0000_7000, 32'h0, 32'h0, 0, 32'h0BAD_0003, 1};
    vecs[4] = '{2'b11, 2'b11, 32'h0000_8000, 32'h0000_9000, 32'h5555_5555, 32'h6666_6666, 1, 32'h0BAD_0004, 0};
    vecs[5] = '{2'b10, 2'b10, 32'h0000_A000, 32'h0000_B000, 32'h0, 32'h7777_0000, 2, 32'h0BAD_0005, 1};
    vecs[6] = '{2'b10, 2'b00, 32'h0000_C000, 32'h0000_D000, 32'h0, 32'h0, 0, 32'h0BAD_0006, 1};
    vecs[7] = '{2'b01, 2'b01, 32'h0000_E000, 32'h0000_F000, 32'h7777_7777, 32'h0, 5, 32'h0BAD_0007, 0};

    reset = 1'b1;
    req_request = '0; req_operation = '0; req_addr = '0; req_wdata = '0;
    nl_rdata = '0; nl_valid = 1'b0; nl_evict = 1'b0;
    tick(); tick(); tick();
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_rdata", 64'(req_rdata), 64'd0);
    check("rst_nl_request", 64'(nl_request), 64'd0);
    check("rst_nl_operation", 64'(nl_operation), 64'd0);
    check("rst_nl_addr", 64'(nl_addr), 64'd0);
    check("rst_nl_wdata", 64'(nl_wdata), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
    end
    req_request = '0;

    // Evict hold-off in IDLE: requester 1 waits until nl_evict drops.
    req_request = 2'b10; req_operation = 2'b00; req_addr = {32'h0000_0444, 32'h0}; nl_evict = 1'b1;
    #1;
    check("req_evict_on", 64'(req_evict), 64'h3);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("evict_holdoff_nl_request", 64'(nl_request), 64'd0);
      check("evict_holdoff_busy", 64'(busy), 64'd0);
      $display("[TB] evict hold cycle %0d nl_request=%0d", c, nl_request);
    end
    nl_evict = 1'b0;
    tick();
    check("evict_grant_nl_request", 64'(nl_request), 64'd1);
    check("evict_grant_id", 64'(grant_id), 64'd1);
    check("evict_grant_addr", 64'(nl_addr), 64'h444);
    req_request = '0;
    finish_txn(1, 32'hC0DE_0001);

    // Evict pulse during ISSUE must not disturb the transaction.
    req_request = 2'b01; req_addr = {32'h0, 32'h0000_0555};
    tick();
    check("evict_issue_grant", 64'(grant_id), 64'd0);
    req_request = '0;
    nl_evict = 1'b1;
    #1;
    check("evict_issue_req_evict_on", 64'(req_evict), 64'h3);
    tick();
    nl_evict = 1'b0;
    #1;
    check("evict_issue_req_evict_off", 64'(req_evict), 64'h0);
    check("evict_issue_nl_request", 64'(nl_request), 64'd1);
    check("evict_issue_addr", 64'(nl_addr), 64'h555);
    $display("[TB] evict during issue, nl_request=%0d", nl_request);
    finish_txn(0, 32'hC0DE_0002);

    // Watchdog: 8 ISSUE cycles without nl_valid abort the transaction.
    check("wdog_err_before", 64'(timeout_err), 64'd0);
    req_request = 2'b01; req_addr = {32'h0, 32'h0000_0666};
    tick();
    check("wdog_grant", 64'(grant_id), 64'd0);
    req_request = '0;
    for (int c = 0; c < 7; c++) begin
      tick();
      check("wdog_still_issue", 64'(nl_request), 64'd1);
    end
    check("wdog_err_not_yet", 64'(timeout_err), 64'd0);
    tick();
    check("wdog_abort_nl_request", 64'(nl_request), 64'd0);
    check("wdog_abort_busy", 64'(busy), 64'd0);
    check("wdog_abort_err", 64'(timeout_err), 64'd1);
    $display("[TB] watchdog abort timeout_err=%0d", timeout_err);
    tick(); tick();
    check("wdog_err_sticky", 64'(timeout_err), 64'd1);
    req_request = 2'b11; req_addr = {32'h0000_0777, 32'h0000_0888};
    tick();
    check("post_wdog_grant", 64'(grant_id), 64'd1);
    check("post_wdog_addr", 64'(nl_addr), 64'h777);
    req_request = '0;
    finish_txn(1, 32'hC0DE_0003);
    check("post_wdog_err_sticky", 64'(timeout_err), 64'd1);

    // Reset during ISSUE of a WRITE aborts without a completion.
    req_request = 2'b10; req_operation = 2'b10; req_addr = {32'h0000_0020, 32'h0};
    req_wdata = {32'hABCD_0020, 32'h0};
    tick();
    check("mid_rst_pre_op", 64'(nl_operation), 64'd1);
    check("mid_rst_pre_addr", 64'(nl_addr), 64'h20);
    check("mid_rst_pre_grant", 64'(grant_id), 64'd1);
    req_request = '0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_nl_request", 64'(nl_request), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err_cleared", 64'(timeout_err), 64'd0);
    check("mid_rst_grant", 64'(grant_id), 64'd0);
    reset = 1'b0;
    req_request = 2'b11; req_operation = 2'b00; req_addr = {32'h0000_0999, 32'h0000_0AAA};
    tick();
    check("post_rst_grant", 64'(grant_id), 64'd0);
    check("post_rst_addr", 64'(nl_addr), 64'hAAA);
    $display("[TB] post-reset grant=%0d", grant_id);
    req_request = '0;
    finish_txn(0, 32'hC0DE_0004);

    tick(); tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
